ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_pkg.sv | 23 ++
 rtl/ram_fifo_obuf.sv | 68 ++++++
 rtl/ram_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// Module : ram_fifo_pkg
// Brief  : Shared defaults and RAM-port operation type for the RAM-backed FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

  localparam int DEF_WIDTH      = 46;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int COUNT_WIDTH    = 6;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_t;

endpackage

`default_nettype wire

// File: rtl/ram_fifo_obuf.sv
// ============================================================================
// Module : ram_fifo_obuf
// Brief  : Two-entry output buffer with a registered head word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_obuf
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= data;
          else               r_tail <= data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the incoming word goes behind whatever remains.
          if (r_cnt == 2'd1) begin
            r_head <= data;
          end else begin
            r_head <= r_tail;
            r_tail <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (r_cnt != 2'd0);
  assign head  = r_head;
  assign cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module : ram_fifo_ctrl
// Brief  : FIFO controller over one external single-port RAM plus a 2-entry
//          output buffer, arbitrating writes and reads round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [WIDTH-1:0]       ram_wd,
  input  logic [WIDTH-1:0]       ram_rd
);

  localparam int   CNT_W     = $clog2(DEPTH + 1);
  localparam logic C_LAST_RD = 1'b0;
  localparam logic C_LAST_WR = 1'b1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_ram_cnt;
  logic                  r_inflight;
  logic                  r_last_op;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [WIDTH-1:0]      r_wd_hold;

  logic [1:0]            w_obuf_cnt;
  logic                  w_rd_want;
  logic                  w_wr_grant;
  logic                  w_pop;
  op_t                   w_op;

  function automatic logic [ADDR_WIDTH-1:0] f_ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == ADDR_WIDTH'(DEPTH - 1)) f_ptr_inc = '0;
    else                               f_ptr_inc = ptr + ADDR_WIDTH'(1);
  endfunction

  // Reads only when the obuf can absorb the word, counting one still in flight.
  assign w_rd_want = !rst && (r_ram_cnt != '0)
                     && (({1'b0, w_obuf_cnt} + {2'b00, r_inflight}) < 3'd2);

  // Yielding to a pending read after a write gives round-robin under contention.
  assign in_ready   = !rst && (r_ram_cnt < CNT_W'(DEPTH))
                      && !(w_rd_want && (r_last_op == C_LAST_WR));
  assign w_wr_grant = in_valid && in_ready;

  always_comb begin
    w_op = OP_IDLE;
    if (w_wr_grant)     w_op = OP_WR;
    else if (w_rd_want) w_op = OP_RD;
  end

  always_comb begin
    ram_ce   = (w_op != OP_IDLE);
    ram_we   = (w_op == OP_WR);
    ram_addr = r_addr_hold;
    ram_wd   = r_wd_hold;
    case (w_op)
      OP_WR: begin
        ram_addr = r_wr_ptr;
        ram_wd   = in_data;
      end
      OP_RD: ram_addr = r_rd_ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_last_op   <= C_LAST_RD;
      r_addr_hold <= '0;
      r_wd_hold   <= '0;
    end else begin
      r_inflight <= (w_op == OP_RD);
      case (w_op)
        OP_WR: begin
          r_wr_ptr  <= f_ptr_inc(r_wr_ptr);
          r_ram_cnt <= r_ram_cnt + CNT_W'(1);
          r_last_op <= C_LAST_WR;
        end
        OP_RD: begin
          r_rd_ptr  <= f_ptr_inc(r_rd_ptr);
          r_ram_cnt <= r_ram_cnt - CNT_W'(1);
          r_last_op <= C_LAST_RD;
        end
        default: ;
      endcase
      if (w_op != OP_IDLE) begin
        r_addr_hold <= ram_addr;
        r_wd_hold   <= ram_wd;
      end
    end
  end

  assign w_pop = out_valid && out_ready;

  // RAM read data is captured only in the cycle after a read was issued.
  ram_fifo_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (r_inflight),
    .data  (ram_rd),
    .pop   (w_pop),
    .valid (out_valid),
    .head  (out_data),
    .cnt   (w_obuf_cnt)
  );

  assign count = COUNT_WIDTH'(r_ram_cnt) + COUNT_WIDTH'(r_inflight)
                 + COUNT_WIDTH'(w_obuf_cnt);

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
// Module : tb_ram_fifo_ctrl
// Brief  : Self-checking bench for ram_fifo_ctrl with a RAM model and a
//          queue-based reference of the FIFO contents.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_fifo_ctrl;

  localparam int W  = 46;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [5:0]    count;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wd;
  logic [W-1:0]  ram_rd;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  q [$];

  int            errors = 0;
  int            checks = 0;
  bit            sb_en  = 1'b0;
  logic          prev_rst;
  logic [AW-1:0] prev_addr;
  logic [W-1:0]  prev_wd;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wd    (ram_wd),
    .ram_rd    (ram_rd)
  );

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom(), $urandom()});
  endfunction

  // Synchronous single-port RAM; the read bus carries noise when no read was issued.
  always @(posedge clk) begin
    if (ram_ce && ram_we) mem[ram_addr] <= ram_wd;
    if (ram_ce && !ram_we) ram_rd <= mem[ram_addr];
    else                   ram_rd <= rnd_word();
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Waits to mid-cycle, checks the DUT against the queue model, then updates the model.
  task automatic sample();
    @(negedge clk);
    if (sb_en) begin
      checks++;
      if (count !== 6'(q.size())) begin
        errors++;
        $display("FAIL sb_count: got %0d expected %0d", count, q.size());
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious_valid: out_valid=1 data=%h with model empty", out_data);
        end else if (out_data !== q[0]) begin
          errors++;
          $display("FAIL sb_head: got %h expected %h", out_data, q[0]);
        end
      end
      checks++;
      if (ram_we && !ram_ce) begin
        errors++;
        $display("FAIL ram_we_without_ce: ram_we=%b ram_ce=%b", ram_we, ram_ce);
      end
      if (!ram_ce && !prev_rst) begin
        checks++;
        if (ram_addr !== prev_addr || ram_wd !== prev_wd) begin
          errors++;
          $display("FAIL idle_hold: addr %h wd %h expected addr %h wd %h",
                   ram_addr, ram_wd, prev_addr, prev_wd);
        end
      end
      if (count == 6'd34 || rst) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_blocked: in_ready=%b count=%0d rst=%b", in_ready, count, rst);
        end
      end
      if (rst) begin
        checks++;
        if (ram_ce !== 1'b0) begin
          errors++;
          $display("FAIL ce_in_reset: ram_ce=%b expected 0", ram_ce);
        end
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(in_data);
      end
    end
    prev_rst  = rst;
    prev_addr = ram_addr;
    prev_wd   = ram_wd;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      sample();
      advance();
      if (q.size() == 0 && count == 6'd0) break;
    end
    sample();
    checks++;
    if (count !== 6'd0) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d expected 0", count);
    end
    advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    advance();
    advance();
    sample();
    checks++;
    if ({in_ready, out_valid, ram_ce, ram_we} !== 4'b0000 || count !== 6'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b ce=%b we=%b count=%0d data=%h expected all 0",
               in_ready, out_valid, ram_ce, ram_we, count, out_data);
    end
    advance();
    rst = 1'b0;
    sb_en = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
    advance();
  endtask

  task automatic test_single();
    logic [W-1:0] v;
    v = 46'h2A5A5A5A5A5;
    in_valid = 1'b1; in_data = v; out_ready = 1'b1;
    sample();
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd0 || ram_wd !== v) begin
      errors++;
      $display("FAIL single_write: ce=%b we=%b addr=%0d wd=%h expected 1 1 0 %h",
               ram_ce, ram_we, ram_addr, ram_wd, v);
    end
    advance();
    in_valid = 1'b0;
    sample();
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd0) begin
      errors++;
      $display("FAIL single_read: ce=%b we=%b addr=%0d expected 1 0 0", ram_ce, ram_we, ram_addr);
    end
    advance();
    sample();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: out_valid=%b in cycle 2 expected 0", out_valid);
    end
    advance();
    sample();
    checks++;
    if (out_valid !== 1'b1 || out_data !== v) begin
      errors++;
      $display("FAIL single_output: vld=%b data=%h expected 1 %h", out_valid, out_data, v);
    end
    advance();
    sample();
    checks++;
    if (count !== 6'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: count=%0d vld=%b expected 0 0", count, out_valid);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    int j = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 200 && acc < 34; c++) begin
      in_valid = 1'b1;
      in_data  = W'(acc);
      sample();
      if (in_ready) acc++;
      advance();
    end
    checks++;
    if (acc != 34) begin
      errors++;
      $display("FAIL fill_timeout: accepted %0d expected 34", acc);
    end
    in_data = W'(99);
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (in_ready !== 1'b0 || count !== 6'd34 || ram_ce !== 1'b0) begin
        errors++;
        $display("FAIL full_idle: rdy=%b count=%0d ce=%b expected 0 34 0", in_ready, count, ram_ce);
      end
      advance();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && j < 34; c++) begin
      sample();
      if (out_valid) begin
        checks++;
        if (out_data !== W'(j)) begin
          errors++;
          $display("FAIL drain_order: got %0d expected %0d", out_data, j);
        end
        j++;
      end
      advance();
    end
    checks++;
    if (j != 34) begin
      errors++;
      $display("FAIL drain_count: popped %0d expected 34", j);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int wraps = 0;
    bit have_prev = 1'b0;
    logic prev_we = 1'b0;
    logic [AW-1:0] last_wr = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 500 && acc < 100; c++) begin
      in_valid = 1'b1;
      in_data  = rnd_word();
      sample();
      if (in_ready) acc++;
      if (ram_ce) begin
        if (have_prev) begin
          checks++;
          if (ram_we === prev_we) begin
            errors++;
            $display("FAIL alternate: op we=%b repeated, expected %b", ram_we, !prev_we);
          end
        end
        if (ram_we) begin
          if (last_wr == 5'd31 && ram_addr == 5'd0) wraps++;
          last_wr = ram_addr;
        end
        prev_we = ram_we;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      advance();
    end
    checks++;
    if (acc != 100 || wraps < 2) begin
      errors++;
      $display("FAIL stream: accepted %0d wraps %0d expected 100 and >=2", acc, wraps);
    end
    drain();
  endtask

  task automatic test_toggle();
    int coinc = 0;
    logic prev_rd = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = rnd_word();
      out_ready = !out_ready;
      sample();
      if (prev_rd && out_valid && out_ready) coinc++;
      prev_rd = ram_ce && !ram_we;
      advance();
    end
    checks++;
    if (coinc == 0) begin
      errors++;
      $display("FAIL toggle_coincide: push+pop cycles %0d expected >0", coinc);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(2) != 0);
      in_data   = rnd_word();
      out_ready = $urandom_range(1) == 1;
      sample();
      advance();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int acc = 0;
    bit found = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 100 && acc < 11; c++) begin
      in_valid = 1'b1;
      in_data  = rnd_word();
      sample();
      if (in_ready) acc++;
      advance();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    out_ready = 1'b1;
    sample();
    advance();
    out_ready = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      sample();
      if (ram_ce && !ram_we && count == 6'd10) found = 1'b1;
      advance();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midflight_setup: no read issued with count=10 (count=%0d)", count);
    end
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    sample();
    checks++;
    if (count !== 6'd0 || out_valid !== 1'b0 || ram_ce !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_reset: count=%0d vld=%b ce=%b rdy=%b expected 0 0 0 1",
               count, out_valid, ram_ce, in_ready);
    end
    advance();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_read: out_valid=%b data=%h expected 0", out_valid, out_data);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_toggle();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
